// File: rtl/scan_pkg.sv
// Purpose : shared mode encodings and default sizes for the scan-chain target.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package scan_pkg;

    typedef enum logic [1:0] {
        MODE_FUNC  = 2'd0,
        MODE_ENTRY = 2'd1,
        MODE_SCAN  = 2'd2,
        MODE_EXIT  = 2'd3
    } mode_e;

    localparam int DEF_CHAIN_LEN = 64;
    localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/scan_shift_reg.sv
// Purpose : CHAIN_LEN-bit state register; serial shift toward bit 0 or +1 functional step.
// Latency : shift_in reaches chain MSB one cycle after shift_en; increment visible next cycle.
// Backpressure: none; shift_en has priority over inc_en (callers never assert both).
// Ports   : aclk/aresetn clock and async active-low reset; shift_en/shift_in serial load;
//           inc_en functional step; chain current register contents.
module scan_shift_reg #(
    parameter int CHAIN_LEN = 64
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 shift_en,
    input  logic                 shift_in,
    input  logic                 inc_en,
    output logic [CHAIN_LEN-1:0] chain
);

    localparam logic [CHAIN_LEN-1:0] ONE = CHAIN_LEN'(1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            chain <= '0;
        end else if (shift_en) begin
            // LSB leaves first, new bit enters at the MSB.
            chain <= {shift_in, chain[CHAIN_LEN-1:1]};
        end else if (inc_en) begin
            chain <= chain + ONE;
        end
    end

endmodule

// File: rtl/scan_chain_target.sv
// Purpose : device-side scan-chain endpoint: functional counter plus scan-shift mode with status flags.
// Latency : scan_input -> chain MSB 1 cycle; chain[1] -> scan_output 1 cycle per shift.
// Backpressure: none; every qualified strobe is accepted, illegal strobes only flag proto_err.
// Ports   : aclk, aresetn; scan_enable/scan_ck_enable/scan_input/scan_output serial scan interface;
//           func_en functional step; func_state, mode, shift_count, chain_wrap, proto_err, overrun
//           observation/status; status_clr clears sticky flags.
// Option  : SCAN_TARGET_PARITY_EN adds the parity output (running XOR of shifted-in bits).
module scan_chain_target
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 scan_enable,
    input  logic                 scan_ck_enable,
    input  logic                 scan_input,
    output logic                 scan_output,
    input  logic                 func_en,
    output logic [CHAIN_LEN-1:0] func_state,
    output logic [1:0]           mode,
    output logic [CNT_W-1:0]     shift_count,
    output logic                 chain_wrap,
    output logic                 proto_err,
    input  logic                 status_clr,
    output logic                 overrun
`ifdef SCAN_TARGET_PARITY_EN
    ,
    output logic                 parity
`endif
);

    localparam int              POS_W    = $clog2(CHAIN_LEN);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(CHAIN_LEN - 1);

    mode_e                 state;
    logic [CHAIN_LEN-1:0]  chain;
    logic [POS_W-1:0]      pos;        // shifts modulo CHAIN_LEN in this session
    logic                  full;       // CHAIN_LEN shifts already done this session

    logic                  in_entry;
    logic                  shift;
    logic                  func_step;
    logic                  proto_set;
    logic [CNT_W-1:0]      cnt_base;
    logic [POS_W-1:0]      pos_base;
    logic                  full_base;
    logic                  cnt_sat;
    logic                  pos_wrap;

    assign in_entry  = (state == MODE_ENTRY);
    assign shift     = scan_enable & scan_ck_enable & (in_entry | (state == MODE_SCAN));
    assign func_step = (state == MODE_FUNC) & ~scan_enable & func_en;
    assign proto_set = scan_ck_enable & ~scan_enable;

    // ENTRY restarts the session; a shift in the same cycle counts from zero.
    always_comb begin
        cnt_base  = in_entry ? '0   : shift_count;
        pos_base  = in_entry ? '0   : pos;
        full_base = in_entry ? 1'b0 : full;
        cnt_sat   = &cnt_base;
        pos_wrap  = shift & (pos_base == POS_LAST);
    end

    scan_shift_reg #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_shift_reg (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .shift_en (shift),
        .shift_in (scan_input),
        .inc_en   (func_step),
        .chain    (chain)
    );

    assign func_state  = chain;
    assign scan_output = chain[0];
    assign mode        = state;

    // Mode sequencing: FUNC -> ENTRY -> SCAN -> EXIT -> FUNC, with re-entry from EXIT.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= MODE_FUNC;
        end else begin
            case (state)
                MODE_FUNC:  if (scan_enable) state <= MODE_ENTRY;
                MODE_ENTRY: state <= scan_enable ? MODE_SCAN : MODE_EXIT;
                MODE_SCAN:  if (!scan_enable) state <= MODE_EXIT;
                MODE_EXIT:  state <= scan_enable ? MODE_ENTRY : MODE_FUNC;
                default:    state <= MODE_FUNC;
            endcase
        end
    end

    // Session counters and status flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            shift_count <= '0;
            pos         <= '0;
            full        <= 1'b0;
            chain_wrap  <= 1'b0;
            overrun     <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            shift_count <= (shift && !cnt_sat) ? cnt_base + CNT_W'(1) : cnt_base;
            pos         <= shift ? (pos_wrap ? '0 : pos_base + POS_W'(1)) : pos_base;
            full        <= full_base | pos_wrap;
            // A saturated counter no longer lands on multiples of CHAIN_LEN.
            chain_wrap  <= pos_wrap & ~cnt_sat;

            // Set events take priority over clears.
            if (shift && full_base)
                overrun <= 1'b1;
            else if (status_clr || in_entry)
                overrun <= 1'b0;

            if (proto_set)
                proto_err <= 1'b1;
            else if (status_clr)
                proto_err <= 1'b0;
        end
    end

`ifdef SCAN_TARGET_PARITY_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            parity <= 1'b0;
        else
            parity <= (in_entry ? 1'b0 : parity) ^ (shift & scan_input);
    end
`endif

endmodule

// File: tb/tb_scan_chain_target.sv
// Purpose : self-checking bench for scan_chain_target (functional count, scan shift, status flags).
// Latency : n/a.
// Backpressure: n/a.
module tb_scan_chain_target;

    localparam int CHAIN_LEN = 64;
    localparam int CNT_W     = 16;

    logic                 aclk = 1'b0;
    logic                 aresetn;
    logic                 scan_enable;
    logic                 scan_ck_enable;
    logic                 scan_input;
    logic                 scan_output;
    logic                 func_en;
    logic [CHAIN_LEN-1:0] func_state;
    logic [1:0]           mode;
    logic [CNT_W-1:0]     shift_count;
    logic                 chain_wrap;
    logic                 proto_err;
    logic                 status_clr;
    logic                 overrun;
`ifdef SCAN_TARGET_PARITY_EN
    logic                 parity;
`endif

    always #5 aclk = ~aclk;

    scan_chain_target #(
        .CHAIN_LEN (CHAIN_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .scan_enable    (scan_enable),
        .scan_ck_enable (scan_ck_enable),
        .scan_input     (scan_input),
        .scan_output    (scan_output),
        .func_en        (func_en),
        .func_state     (func_state),
        .mode           (mode),
        .shift_count    (shift_count),
        .chain_wrap     (chain_wrap),
        .proto_err      (proto_err),
        .status_clr     (status_clr),
        .overrun        (overrun)
`ifdef SCAN_TARGET_PARITY_EN
        ,
        .parity         (parity)
`endif
    );

    int          total = 0;
    int          bad   = 0;
    int          wrap_seen = 0;
    logic [63:0] mdl;        // reference chain contents
    logic [63:0] out_word;   // scan_output captured before each shift
    logic        exp_q[$];   // expected scan_output after each shift

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        wrap_seen += int'(chain_wrap);
    endtask

    task automatic enter();
        scan_enable = 1'b1;
        tick();
        chk("mode_entry", 64'(mode), 64'd1);
    endtask

    task automatic leave();
        scan_enable = 1'b0;
        tick();
        chk("mode_exit", 64'(mode), 64'd3);
        tick();
        chk("mode_func", 64'(mode), 64'd0);
    endtask

    task automatic shift_bits(input logic [63:0] din, input int n);
        for (int i = 0; i < n; i++) begin
            scan_ck_enable   = 1'b1;
            scan_input       = din[i % 64];
            out_word[i % 64] = scan_output;
            mdl              = {din[i % 64], mdl[63:1]};
            exp_q.push_back(mdl[0]);
            tick();
            chk("scan_out", 64'(scan_output), 64'(exp_q.pop_front()));
        end
        scan_ck_enable = 1'b0;
        scan_input     = 1'b0;
    endtask

    task automatic func_steps(input int n);
        func_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            mdl = mdl + 64'd1;
        end
        func_en = 1'b0;
    endtask

    initial begin
        aresetn        = 1'b0;
        scan_enable    = 1'b0;
        scan_ck_enable = 1'b0;
        scan_input     = 1'b0;
        func_en        = 1'b0;
        status_clr     = 1'b0;
        mdl            = '0;
        out_word       = '0;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_state",   func_state, 64'd0);
        chk("rst_mode",    64'(mode), 64'd0);
        chk("rst_count",   64'(shift_count), 64'd0);
        chk("rst_wrap",    64'(chain_wrap), 64'd0);
        chk("rst_proto",   64'(proto_err), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_sout",    64'(scan_output), 64'd0);
        aresetn = 1'b1;
        tick();

        // 1: functional counting
        func_steps(10);
        chk("t1_state", func_state, 64'd10);
        chk("t1_mode",  64'(mode), 64'd0);
        chk("t1_sout",  64'(scan_output), 64'd0);

        // 2: load via scan, then shift it back out LSB-first
        enter();
        shift_bits(64'h0123_4567_89AB_CDEF, 64);
        leave();
        chk("t2_loaded", func_state, 64'h0123_4567_89AB_CDEF);
        enter();
        chk("t2_sout0", 64'(scan_output), 64'd1);
        wrap_seen = 0;
        shift_bits(64'd0, 64);
        chk("t2_mode_scan", 64'(mode), 64'd2);
        chk("t2_outword",   out_word, 64'h0123_4567_89AB_CDEF);
        chk("t2_chain",     func_state, 64'd0);
        chk("t2_count",     64'(shift_count), 64'd64);
        leave();
        chk("t2_wraps",     64'(wrap_seen), 64'd1);

        // 3: scan in a value, return to functional mode and step once
        enter();
        shift_bits(64'hDEAD_BEEF_CAFE_F00D, 64);
        leave();
        func_steps(1);
        chk("t3_state", func_state, 64'hDEAD_BEEF_CAFE_F00E);
        chk("t3_model", func_state, mdl);

        // 4: overrun on the 65th shift, sticky, cleared by status_clr and by ENTRY
        enter();
        shift_bits({$urandom, $urandom}, 1);
        chk("t4_count1",    64'(shift_count), 64'd1);
        shift_bits({$urandom, $urandom}, 63);
        chk("t4_ovr64",     64'(overrun), 64'd0);
        chk("t4_count64",   64'(shift_count), 64'd64);
        shift_bits({$urandom, $urandom}, 1);
        chk("t4_ovr65",     64'(overrun), 64'd1);
        chk("t4_count65",   64'(shift_count), 64'd65);
        tick();
        chk("t4_ovr_stick", 64'(overrun), 64'd1);
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        chk("t4_ovr_clr",   64'(overrun), 64'd0);
        shift_bits({$urandom, $urandom}, 1);
        chk("t4_ovr_again", 64'(overrun), 64'd1);
        leave();
        enter();
        tick();
        chk("t4_ovr_entry", 64'(overrun), 64'd0);
        chk("t4_cnt_entry", 64'(shift_count), 64'd0);
        leave();

        // 5: strobe without scan_enable
        chk("t5_proto0", 64'(proto_err), 64'd0);
        scan_ck_enable = 1'b1;
        tick();
        scan_ck_enable = 1'b0;
        chk("t5_proto1", 64'(proto_err), 64'd1);
        chk("t5_chain",  func_state, mdl);
        chk("t5_count",  64'(shift_count), 64'd0);
        status_clr     = 1'b1;
        scan_ck_enable = 1'b1;
        tick();
        scan_ck_enable = 1'b0;
        chk("t5_setwins", 64'(proto_err), 64'd1);
        tick();
        status_clr = 1'b0;
        chk("t5_clr",     64'(proto_err), 64'd0);
        chk("t5_chain2",  func_state, mdl);

        // 6: asynchronous reset in the middle of a session
        enter();
        shift_bits({$urandom, $urandom}, 20);
        chk("t6_count20", 64'(shift_count), 64'd20);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_chain", func_state, 64'd0);
        chk("t6_count", 64'(shift_count), 64'd0);
        chk("t6_mode",  64'(mode), 64'd0);
        chk("t6_sout",  64'(scan_output), 64'd0);
        scan_enable = 1'b0;
        tick();
        aresetn = 1'b1;
        mdl     = '0;
        tick();

`ifdef SCAN_TARGET_PARITY_EN
        enter();
        shift_bits(64'hB, 4);
        chk("t6_parity",     64'(parity), 64'd1);
        leave();
        enter();
        tick();
        chk("t6_parity_clr", 64'(parity), 64'd0);
        leave();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
